// File: rtl/uctl_cdc_hs_sender.sv
// Source side of a four-phase req/ack handshake across clock domains.
// Captures a word on valid/ready, raises reqOut and waits for the remote ack to rise and fall.
module uctl_cdc_hs_sender #(
  parameter int DATA_WIDTH = 32,
  parameter bit BYPASS     = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  srcValid,
  input  logic [DATA_WIDTH-1:0] srcData,
  output logic                  srcReady,
  input  logic                  ackIn,
  output logic                  reqOut,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    ack_sync_s;
  logic                    accept_s;
  logic                    done_nxt_s;
  logic                    req_r;
  logic                    done_r;
  logic [DATA_WIDTH-1:0]   data_r;

  generate
    if (BYPASS == 1'b0) begin : g_sync
      logic ack_meta_r;
      logic ack_sync_r;

      // Two-flop synchronizer for the asynchronous acknowledge.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ack_meta_r <= 1'b0;
          ack_sync_r <= 1'b0;
        end else begin
          ack_meta_r <= ackIn;
          ack_sync_r <= ack_meta_r;
        end
      end

      assign ack_sync_s = ack_sync_r;
    end else begin : g_bypass
      assign ack_sync_s = ackIn;
    end
  endgenerate

  // A stale high ack in IDLE blocks new requests until the remote side releases it.
  assign srcReady = (state_r == IDLE) && !ack_sync_s;
  assign accept_s = srcValid && srcReady;

  // Next-state logic for the four-phase handshake.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = REQ_HI;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ_HI: begin
        if (ack_sync_s) begin
          state_nxt_s = REQ_LO;
        end else begin
          state_nxt_s = REQ_HI;
        end
      end
      REQ_LO: begin
        if (!ack_sync_s) begin
          state_nxt_s = IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = REQ_LO;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; dataOut only loads on accept so it is stable for the whole transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      done_r  <= 1'b0;
      data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      req_r   <= (state_nxt_s == REQ_HI);
      done_r  <= done_nxt_s;
      if (accept_s) begin
        data_r <= srcData;
      end
    end
  end

  assign reqOut  = req_r;
  assign dataOut = data_r;
  assign done    = done_r;
  assign busy    = (state_r != IDLE);

endmodule

// File: tb/tb_uctl_cdc_hs_sender.sv
// Bench for uctl_cdc_hs_sender: a synchronized (dut0) and a bypassed (dut1) instance,
// checked every cycle against a rule-level reference model plus directed timing checks.
module tb_uctl_cdc_hs_sender;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          src_valid [2];
  logic [DW-1:0] src_data  [2];
  logic          src_ready [2];
  logic          ack_in    [2];
  logic          req_out   [2];
  logic [DW-1:0] data_out  [2];
  logic          busy      [2];
  logic          done      [2];

  uctl_cdc_hs_sender #(.DATA_WIDTH(DW), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .srcValid(src_valid[0]), .srcData(src_data[0]),
    .srcReady(src_ready[0]), .ackIn(ack_in[0]), .reqOut(req_out[0]),
    .dataOut(data_out[0]), .busy(busy[0]), .done(done[0]));

  uctl_cdc_hs_sender #(.DATA_WIDTH(DW), .BYPASS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .srcValid(src_valid[1]), .srcData(src_data[1]),
    .srcReady(src_ready[1]), .ackIn(ack_in[1]), .reqOut(req_out[1]),
    .dataOut(data_out[1]), .busy(busy[1]), .done(done[1]));

  always #5 clk = ~clk;

  int checks;
  int errors;
  int cyc;

  // reference model: phase 0 idle, 1 waiting ack high, 2 waiting ack low
  int            m_phase [2];
  logic [DW-1:0] m_data  [2];
  logic          m_done  [2];
  logic          m_acc   [2];
  logic          h0 [2];
  logic          h1 [2];
  logic          sb_v;
  logic          sa_v;

  // observations of DUT outputs
  logic          prev_req [2];
  int            t_fall   [2];
  int            t_done   [2];
  int            done_cnt [2];
  int            n_obs    [2];
  logic [DW-1:0] obs      [2][0:63];
  int            rt       [2][0:63];

  // responder: 0 random ack, 1 follow reqOut after rdelay cycles, 2 manual
  int rmode;
  int rdelay [2];
  int rcnt   [2];
  int t_ackr [2];
  int t_ackf [2];

  // source word queues
  logic [DW-1:0] wq [2][0:63];
  int            wr [2];
  int            wn [2];
  int            gap_en;

  task automatic check(input string name, input int i, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", name, i, $time, act, exp);
    end
  endtask

  task automatic load(input int i, input logic [DW-1:0] w);
    wq[i][wn[i]] = w;
    wn[i]++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(wr[0] == wn[0] && wr[1] == wn[1] && m_phase[0] == 0 && m_phase[1] == 0 &&
             !src_valid[0] && !src_valid[1]) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL timeout_%s actual=%0d cycles expected<%0d", name, n, budget);
    end
  endtask

  // Model update at each edge, then compare one time unit later.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!reset) begin
          m_phase[i] = 0;
          m_data[i]  = '0;
          m_done[i]  = 1'b0;
          m_acc[i]   = 1'b0;
          h0[i]      = 1'b0;
          h1[i]      = 1'b0;
        end else begin
          // ack level seen by the design at this edge: ackIn two edges ago, or live when bypassed
          sb_v      = (i == 1) ? ack_in[i] : h1[i];
          m_acc[i]  = 1'b0;
          m_done[i] = 1'b0;
          if (m_phase[i] == 0) begin
            if (src_valid[i] && !sb_v) begin
              m_phase[i] = 1;
              m_data[i]  = src_data[i];
              m_acc[i]   = 1'b1;
            end
          end else if (m_phase[i] == 1) begin
            if (sb_v) m_phase[i] = 2;
          end else begin
            if (!sb_v) begin
              m_phase[i] = 0;
              m_done[i]  = 1'b1;
            end
          end
          h1[i] = h0[i];
          h0[i] = ack_in[i];
        end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        sa_v = (i == 1) ? ack_in[i] : h1[i];
        check("reqOut", i, 32'(req_out[i]), 32'(m_phase[i] == 1));
        check("dataOut", i, data_out[i], m_data[i]);
        check("busy", i, 32'(busy[i]), 32'(m_phase[i] != 0));
        check("done", i, 32'(done[i]), 32'(m_done[i]));
        check("srcReady", i, 32'(src_ready[i]), 32'(m_phase[i] == 0 && !sa_v));
        if (req_out[i] && !prev_req[i]) begin
          obs[i][n_obs[i]] = data_out[i];
          rt[i][n_obs[i]]  = cyc;
          n_obs[i]++;
        end
        if (!req_out[i] && prev_req[i]) t_fall[i] = cyc;
        if (done[i]) begin
          t_done[i] = cyc;
          done_cnt[i]++;
        end
        prev_req[i] = req_out[i];
      end
    end
  end

  // Remote-side responder driving ackIn away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rmode == 0) begin
          if ($urandom_range(0, 3) == 0) ack_in[i] = ~ack_in[i];
        end else if (rmode == 1) begin
          if (ack_in[i] != req_out[i]) begin
            rcnt[i]++;
            if (rcnt[i] >= rdelay[i]) begin
              ack_in[i] = req_out[i];
              rcnt[i]   = 0;
              if (ack_in[i]) t_ackr[i] = cyc + 1;
              else           t_ackf[i] = cyc + 1;
            end
          end else begin
            rcnt[i] = 0;
          end
        end
      end
    end
  end

  // Local source: holds each word until the model says it was accepted.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (m_acc[i]) begin
          wr[i]++;
          src_valid[i] = 1'b0;
        end
        if (!src_valid[i]) begin
          if (wr[i] < wn[i] && (gap_en == 0 || $urandom_range(0, 1) == 1)) begin
            src_valid[i] = 1'b1;
            src_data[i]  = wq[i][wr[i]];
          end else begin
            src_data[i] = $urandom;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=no_finish expected=finish");
    $fatal(1);
  end

  initial begin
    int o0 [2];
    int d0 [2];
    int lcyc;
    int n;
    checks = 0; errors = 0; cyc = 0; rmode = 0; gap_en = 0;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      src_valid[i] = 1'b0; src_data[i] = '0; ack_in[i] = 1'b0;
      m_phase[i] = 0; m_data[i] = '0; m_done[i] = 1'b0; m_acc[i] = 1'b0;
      h0[i] = 1'b0; h1[i] = 1'b0; prev_req[i] = 1'b0;
      t_fall[i] = 0; t_done[i] = 0; done_cnt[i] = 0; n_obs[i] = 0;
      rdelay[i] = 1; rcnt[i] = 0; t_ackr[i] = 0; t_ackf[i] = 0; wr[i] = 0; wn[i] = 0;
    end

    // reset held with random ack activity
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_req", i, 32'(req_out[i]), 32'd0);
      check("rst_data", i, data_out[i], 32'h0000_0000);
      check("rst_busy", i, 32'(busy[i]), 32'd0);
      check("rst_done", i, 32'(done[i]), 32'd0);
    end
    check("rst_ready", 0, 32'(src_ready[0]), 32'd1);
    @(negedge clk);
    rmode = 1;
    wait_idle("settle", 50);
    repeat (4) @(posedge clk);
    #2;

    // single transfer, ack 3 cycles after each reqOut edge
    for (int i = 0; i < 2; i++) begin
      rdelay[i] = 3; o0[i] = n_obs[i]; d0[i] = done_cnt[i];
      load(i, 32'hDEAD_BEEF);
    end
    wait_idle("single", 100);
    for (int i = 0; i < 2; i++) begin
      check("st_data", i, obs[i][o0[i]], 32'hDEAD_BEEF);
      check("st_ack_delay", i, 32'(t_ackr[i] - rt[i][o0[i]]), 32'd3);
      check("st_req_fall", i, 32'(t_fall[i] - t_ackr[i]), (i == 0) ? 32'd2 : 32'd0);
      check("st_done_pos", i, 32'(t_done[i] - t_ackf[i]), (i == 0) ? 32'd2 : 32'd0);
      check("st_done_width", i, 32'(done_cnt[i] - d0[i]), 32'd1);
    end
    check("bypass_gain", 0, 32'((t_fall[0] - rt[0][o0[0]]) - (t_fall[1] - rt[1][o0[1]])), 32'd2);

    // back-to-back with an instant responder
    for (int i = 0; i < 2; i++) begin
      rdelay[i] = 1; o0[i] = n_obs[i]; d0[i] = done_cnt[i];
      load(i, 32'd1); load(i, 32'd2); load(i, 32'd3);
    end
    wait_idle("b2b", 100);
    for (int i = 0; i < 2; i++) begin
      check("b2b_dones", i, 32'(done_cnt[i] - d0[i]), 32'd3);
      check("b2b_reqs", i, 32'(n_obs[i] - o0[i]), 32'd3);
      for (int k = 0; k < 3; k++) begin
        check("b2b_word", i, obs[i][o0[i] + k], 32'(k + 1));
      end
      check("b2b_period", i, 32'(rt[i][o0[i] + 1] - rt[i][o0[i]]), (i == 0) ? 32'd7 : 32'd3);
      check("b2b_period2", i, 32'(rt[i][o0[i] + 2] - rt[i][o0[i] + 1]), (i == 0) ? 32'd7 : 32'd3);
    end

    // stuck ack while idle
    @(negedge clk);
    rmode = 2;
    ack_in[0] = 1'b1; ack_in[1] = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      o0[i] = n_obs[i];
      load(i, 32'h0000_0055);
    end
    repeat (6) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      check("stuck_noreq", i, 32'(n_obs[i] - o0[i]), 32'd0);
      check("stuck_ready", i, 32'(src_ready[i]), 32'd0);
    end
    @(negedge clk);
    ack_in[0] = 1'b0; ack_in[1] = 1'b0;
    lcyc = cyc + 1;
    rmode = 1;
    wait_idle("stuck", 100);
    for (int i = 0; i < 2; i++) begin
      check("stuck_release", i, 32'(rt[i][o0[i]] - lcyc), (i == 0) ? 32'd2 : 32'd0);
      check("stuck_data", i, obs[i][o0[i]], 32'h0000_0055);
    end

    // reset while REQ_HI
    for (int i = 0; i < 2; i++) begin
      rdelay[i] = 5;
      load(i, 32'hA5A5_0001);
    end
    n = 0;
    while (m_phase[0] != 1 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("mid_reach_req", 0, 32'(m_phase[0]), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("mid_req", i, 32'(req_out[i]), 32'd0);
      check("mid_data", i, data_out[i], 32'h0000_0000);
      check("mid_busy", i, 32'(busy[i]), 32'd0);
      check("mid_done", i, 32'(done[i]), 32'd0);
      check("mid_ready", i, 32'(src_ready[i]), 32'd1);
      d0[i] = done_cnt[i];
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      check("mid_nodone", i, 32'(done_cnt[i] - d0[i]), 32'd0);
      load(i, 32'hA5A5_0002);
    end
    wait_idle("after_reset", 100);
    for (int i = 0; i < 2; i++) begin
      check("mid_next_done", i, 32'(done_cnt[i] - d0[i]), 32'd1);
      check("mid_next_data", i, obs[i][n_obs[i] - 1], 32'hA5A5_0002);
    end

    // randomized ack activity and source gaps
    gap_en = 1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 20; k++) load(i, $urandom);
    end
    rmode = 0;
    repeat (300) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) rdelay[i] = int'($urandom_range(1, 4));
    rmode = 1;
    wait_idle("random1", 800);
    for (int i = 0; i < 2; i++) begin
      rdelay[i] = int'($urandom_range(1, 4));
      for (int k = 0; k < 10; k++) load(i, $urandom);
    end
    wait_idle("random2", 800);

    // every loaded word appears exactly once, in order; only the reset-dropped one lacks a done
    for (int i = 0; i < 2; i++) begin
      check("total_reqs", i, 32'(n_obs[i]), 32'(wn[i]));
      check("total_done", i, 32'(done_cnt[i]), 32'(wn[i] - 1));
      for (int k = 0; k < wn[i]; k++) begin
        if (k < n_obs[i]) check("seq_word", i, obs[i][k], wq[i][k]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
